// File: rtl/cpu_defs.sv
// Shared CPU definitions: mul/div opcodes plus the
// request bundle and state type of the mul/div scheduler.
package cpu_defs;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_MULT,
    OP_MULTU,
    OP_MUL,
    OP_MADD,
    OP_MADDU,
    OP_MSUB,
    OP_MSUBU,
    OP_DIV,
    OP_DIVU
  } Oper_t;

  typedef struct packed {
    Oper_t       op;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [63:0] hilo;
  } mdu_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN_A,
    ST_RUN_B,
    ST_HOLD
  } muldiv_sched_state_t;

  // MUL only returns a GPR value; every other unit op lands in HI/LO
  function automatic logic op_writes_hilo(Oper_t op);
    return (op != OP_MUL) && (op != OP_NOP);
  endfunction

endpackage

// File: rtl/muldiv_sched_if.sv
// Bus between the mul/div scheduler (master) and the
// shared multi-cycle mul/div unit (slave).
interface muldiv_sched_if;
  import cpu_defs::*;

  Oper_t       mdu_op;
  logic [31:0] mdu_reg1;
  logic [31:0] mdu_reg2;
  logic [63:0] mdu_hilo;
  logic        mdu_flush;
  logic [63:0] mdu_ret;
  logic        mdu_busy;

  modport master (
    output mdu_op,
    output mdu_reg1,
    output mdu_reg2,
    output mdu_hilo,
    output mdu_flush,
    input  mdu_ret,
    input  mdu_busy
  );

  modport slave (
    input  mdu_op,
    input  mdu_reg1,
    input  mdu_reg2,
    input  mdu_hilo,
    input  mdu_flush,
    output mdu_ret,
    output mdu_busy
  );

endinterface

// File: rtl/muldiv_sched.sv
// Shares one mul/div unit between EX slots A (older) and B,
// forwarding A's HI/LO result into B's accumulate operand.
module muldiv_sched
  import cpu_defs::*;
#(
  parameter int TIMEOUT_CYC = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_advance,
  input  logic        a_valid,
  input  Oper_t       a_op,
  input  logic [31:0] a_reg1,
  input  logic [31:0] a_reg2,
  input  logic [63:0] a_hilo,
  input  logic        b_valid,
  input  Oper_t       b_op,
  input  logic [31:0] b_reg1,
  input  logic [31:0] b_reg2,
  input  logic [63:0] b_hilo,
  output logic        stall,
  output logic [63:0] a_ret,
  output logic [63:0] b_ret,
  muldiv_sched_if.master mdu
);

  muldiv_sched_state_t state_q;
  mdu_req_t            req_a;
  mdu_req_t            req_b;
  mdu_req_t            drive;
  logic                b_pend;
  logic                kill;
  logic                running;
  logic                done;
  logic [63:0]         fwd_hilo;
  logic [7:0]          run_cyc;

  assign kill    = rst | flush;
  assign running = (state_q == ST_RUN_A)
                 | (state_q == ST_RUN_B);
  assign done    = running & ~mdu.mdu_busy;

  assign stall = running
               | ((state_q == ST_IDLE)
                  & (a_valid | b_valid));

  assign fwd_hilo = op_writes_hilo(req_a.op)
                  ? mdu.mdu_ret : req_b.hilo;

  always_comb begin
    drive = '0;
    unique case (1'b1)
      state_q == ST_RUN_A: drive = req_a;
      state_q == ST_RUN_B: drive = req_b;
      default:             drive = '0;
    endcase
  end

  assign mdu.mdu_op    = drive.op;
  assign mdu.mdu_reg1  = drive.reg1;
  assign mdu.mdu_reg2  = drive.reg2;
  assign mdu.mdu_hilo  = drive.hilo;
  assign mdu.mdu_flush = kill;

  always_ff @(posedge clk) begin
    if (kill) begin
      state_q <= ST_IDLE;
      req_a   <= '0;
      req_b   <= '0;
      b_pend  <= 1'b0;
      a_ret   <= '0;
      b_ret   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (a_valid) begin
            req_a   <= '{a_op, a_reg1, a_reg2, a_hilo};
            req_b   <= '{b_op, b_reg1, b_reg2, b_hilo};
            b_pend  <= b_valid;
            state_q <= ST_RUN_A;
          end else if (b_valid) begin
            req_b   <= '{b_op, b_reg1, b_reg2, b_hilo};
            b_pend  <= 1'b1;
            state_q <= ST_RUN_B;
          end
        end
        ST_RUN_A: begin
          if (done) begin
            a_ret <= mdu.mdu_ret;
            if (b_pend) begin
              req_b.hilo <= fwd_hilo;
              state_q    <= ST_RUN_B;
            end else begin
              state_q <= ST_HOLD;
            end
          end
        end
        ST_RUN_B: begin
          if (done) begin
            b_ret   <= mdu.mdu_ret;
            b_pend  <= 1'b0;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (ex_advance)
            state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Watchdog: cycles already spent in the current RUN state
  always_ff @(posedge clk) begin
    if (kill || !running || done)
      run_cyc <= '0;
    else if (run_cyc != 8'hFF)
      run_cyc <= run_cyc + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!kill && running)
      assert (int'(run_cyc) < TIMEOUT_CYC)
        else $error("muldiv_sched: run watchdog expired");
    if (!rst)
      assert (!(ex_advance && stall))
        else $error("muldiv_sched: ex_advance while stalled");
  end

endmodule
